// File: rtl/control_pkg.sv
// Shared state encoding, ALU opcodes and select codes for the
// ARM data-path control unit.
package control_pkg;

  typedef enum logic [4:0] {
    S_RESET   = 5'd0,
    S_FETCH0  = 5'd1,
    S_FETCH1  = 5'd2,
    S_FETCH2  = 5'd3,
    S_DECODE  = 5'd4,
    S_DP      = 5'd5,
    S_MEMADDR = 5'd6,
    S_ST0     = 5'd7,
    S_ST1     = 5'd8,
    S_LD0     = 5'd9,
    S_LD1     = 5'd10,
    S_LINK    = 5'd11,
    S_BR      = 5'd12,
    S_FAULT   = 5'd13
  } state_t;

  localparam logic [3:0] ALU_ADD = 4'b0100;
  localparam logic [3:0] ALU_SUB = 4'b0010;
  localparam logic [3:0] ALU_MOV = 4'b1101;

  localparam logic SALU_ALUA = 1'b0;
  localparam logic SALU_IR   = 1'b1;

  localparam logic [1:0] SALUB_MDR   = 2'd0;
  localparam logic [1:0] SALUB_K4    = 2'd1;
  localparam logic [1:0] SALUB_BREXT = 2'd2;
  localparam logic [1:0] SALUB_SHF   = 2'd3;

  localparam logic [1:0] SRA_RN  = 2'd0;
  localparam logic [1:0] SRA_R15 = 2'd1;

  localparam logic [1:0] SRB_RN  = 2'd0;
  localparam logic [1:0] SRB_R15 = 2'd1;
  localparam logic [1:0] SRB_RD  = 2'd2;
  localparam logic [1:0] SRB_RM  = 2'd3;

  localparam logic [1:0] WRA_RD  = 2'd0;
  localparam logic [1:0] WRA_R15 = 2'd1;
  localparam logic [1:0] WRA_R14 = 2'd2;

  localparam logic SSOP_IMM = 1'b0;
  localparam logic SSOP_REG = 1'b1;
  localparam logic SMA_ALU  = 1'b0;
  localparam logic SMA_MEM  = 1'b1;
  localparam logic RW_WR    = 1'b0;
  localparam logic RW_RD    = 1'b1;

  localparam logic [1:0] DSS_WORD = 2'd0;
  localparam logic [1:0] DSS_IR   = 2'd1;
  localparam logic [1:0] SISE_DP  = 2'd0;
  localparam logic [1:0] SISE_MEM = 2'd1;

  function automatic logic cond_pass(
    input logic [3:0] cond,
    input logic [3:0] flags
  );
    logic n, z, c, v;
    {n, z, c, v} = flags;
    unique case (cond)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return c;
      4'h3: return !c;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return c && !z;
      4'h9: return !c || z;
      4'ha: return n == v;
      4'hb: return n != v;
      4'hc: return !z && (n == v);
      4'hd: return z || (n != v);
      4'he: return 1'b1;
      4'hf: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/condition_tester.sv
// Combinational ARM condition-code check of IR[31:28]
// against the NZCV flags.
module condition_tester
  import control_pkg::*;
(
  input  logic [3:0] i_cond,
  input  logic [3:0] i_flags,
  output logic       o_pass
);

  assign o_pass = cond_pass(i_cond, i_flags);

endmodule

// File: rtl/control_unit.sv
// Control FSM for the ARM data path: fetch, decode, DP,
// LDR/STR, B/BL, plus a memory-handshake timeout.
module control_unit
  import control_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int TO_W        = 4
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic [31:0] IR,
  input  logic        MFC,
  input  logic [3:0]  Flags,
  output logic        MFA,
  output logic        RW_RAM,
  output logic        SALU,
  output logic        RF_RW,
  output logic        SSAB,
  output logic        SSOP,
  output logic        SMA,
  output logic        STA,
  output logic        MAR_EN,
  output logic        SR_EN,
  output logic        MDR_EN,
  output logic        IR_EN,
  output logic        SHT_EN,
  output logic        ISE_EN,
  output logic        SGN_EN,
  output logic [1:0]  DSS,
  output logic [1:0]  WRA,
  output logic [1:0]  SRA,
  output logic [1:0]  SRB,
  output logic [1:0]  SISE,
  output logic [1:0]  SALUB,
  output logic [3:0]  ALUA,
  output logic        DP_CLR,
  output logic        FAULT,
  output logic [4:0]  STATE
);

  state_t          r_state;
  state_t          w_next;
  logic [TO_W-1:0] r_cnt;
  logic            w_pass;
  logic            w_wait;
  logic            w_expire;
  logic            w_unused_ir;

  condition_tester u_cond (
    .i_cond  (IR[31:28]),
    .i_flags (Flags),
    .o_pass  (w_pass)
  );

  assign w_unused_ir = ^IR[19:0];

  assign w_wait = (r_state == S_FETCH2) ||
                  (r_state == S_ST1) ||
                  (r_state == S_LD0);

  // r_cnt holds prior idle wait cycles; this one is the last allowed
  assign w_expire = w_wait && !MFC &&
                    (r_cnt == TO_W'(MEM_TIMEOUT - 1));

  assign STATE = r_state;

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) r_state <= S_RESET;
    else      r_state <= w_next;
  end

  // wait states are never adjacent, so clearing outside them
  // amounts to clearing on entry
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR)        r_cnt <= '0;
    else if (!w_wait) r_cnt <= '0;
    else if (!MFC)   r_cnt <= r_cnt + TO_W'(1);
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_RESET:  w_next = S_FETCH0;
      S_FETCH0: w_next = S_FETCH1;
      S_FETCH1: w_next = S_FETCH2;
      S_FETCH2: begin
        if (MFC)           w_next = S_DECODE;
        else if (w_expire) w_next = S_FAULT;
      end
      S_DECODE: begin
        w_next = S_FETCH0;
        if (w_pass) begin
          unique case (1'b1)
            (IR[27:26] == 2'b00):
              w_next = S_DP;
            (IR[27:25] == 3'b010):
              w_next = S_MEMADDR;
            (IR[27:25] == 3'b101):
              w_next = IR[24] ? S_LINK : S_BR;
            default: w_next = S_FETCH0;
          endcase
        end
      end
      S_DP:      w_next = S_FETCH0;
      S_MEMADDR: w_next = IR[20] ? S_LD0 : S_ST0;
      S_ST0:     w_next = S_ST1;
      S_ST1: begin
        if (MFC)           w_next = S_FETCH0;
        else if (w_expire) w_next = S_FAULT;
      end
      S_LD0: begin
        if (MFC)           w_next = S_LD1;
        else if (w_expire) w_next = S_FAULT;
      end
      S_LD1:   w_next = S_FETCH0;
      S_LINK:  w_next = S_BR;
      S_BR:    w_next = S_FETCH0;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_RESET;
    endcase
  end

  always_comb begin
    MFA    = 1'b0;
    RW_RAM = RW_WR;
    SALU   = SALU_ALUA;
    RF_RW  = 1'b0;
    SSAB   = 1'b0;
    SSOP   = SSOP_IMM;
    SMA    = SMA_ALU;
    STA    = 1'b0;
    MAR_EN = 1'b0;
    SR_EN  = 1'b0;
    MDR_EN = 1'b0;
    IR_EN  = 1'b0;
    SHT_EN = 1'b0;
    ISE_EN = 1'b0;
    SGN_EN = 1'b0;
    DSS    = DSS_WORD;
    WRA    = WRA_RD;
    SRA    = SRA_RN;
    SRB    = SRB_RN;
    SISE   = SISE_DP;
    SALUB  = SALUB_MDR;
    ALUA   = 4'b0000;
    DP_CLR = 1'b0;
    FAULT  = 1'b0;
    unique case (r_state)
      S_RESET: DP_CLR = 1'b1;
      S_FETCH0: begin
        ALUA   = ALU_MOV;
        SALUB  = SALUB_SHF;
        SSOP   = SSOP_REG;
        SRB    = SRB_R15;
        MAR_EN = 1'b1;
      end
      S_FETCH1: begin
        SRA    = SRA_R15;
        SALUB  = SALUB_K4;
        ALUA   = ALU_ADD;
        WRA    = WRA_R15;
        RF_RW  = 1'b1;
        MFA    = 1'b1;
        RW_RAM = RW_RD;
      end
      S_FETCH2: begin
        MFA    = 1'b1;
        RW_RAM = RW_RD;
        IR_EN  = 1'b1;
      end
      S_DP: begin
        SALU   = SALU_IR;
        SRB    = SRB_RM;
        SHT_EN = 1'b1;
        if (IR[25]) ISE_EN = 1'b1;
        else        SSOP   = SSOP_REG;
        // compare/test opcodes only update flags
        RF_RW  = (IR[24:23] != 2'b10);
        SR_EN  = IR[20];
      end
      S_MEMADDR: begin
        SALUB  = SALUB_SHF;
        ISE_EN = 1'b1;
        SISE   = SISE_MEM;
        MAR_EN = 1'b1;
        ALUA   = IR[23] ? ALU_ADD : ALU_SUB;
      end
      S_ST0: begin
        SRB    = SRB_RD;
        ALUA   = ALU_MOV;
        SALUB  = SALUB_SHF;
        SSOP   = SSOP_REG;
        MDR_EN = 1'b1;
      end
      S_ST1: begin
        MFA = 1'b1;
        DSS = DSS_IR;
      end
      S_LD0: begin
        MFA    = 1'b1;
        RW_RAM = RW_RD;
        DSS    = DSS_IR;
        SMA    = SMA_MEM;
        SGN_EN = 1'b1;
        MDR_EN = 1'b1;
      end
      S_LD1: begin
        ALUA  = ALU_MOV;
        RF_RW = 1'b1;
      end
      S_LINK: begin
        SRB   = SRB_R15;
        SALUB = SALUB_SHF;
        SSOP  = SSOP_REG;
        ALUA  = ALU_MOV;
        WRA   = WRA_R14;
        RF_RW = 1'b1;
      end
      S_BR: begin
        SRA   = SRA_R15;
        SALUB = SALUB_BREXT;
        ALUA  = ALU_ADD;
        WRA   = WRA_R15;
        RF_RW = 1'b1;
      end
      S_FAULT: FAULT = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed and random instructions
// checked cycle by cycle against an instruction-level model.
module tb_control_unit;
  import control_pkg::*;

  localparam int TMO = 15;

  logic        CLK = 1'b0;
  logic        CLR;
  logic [31:0] IR;
  logic        MFC;
  logic [3:0]  Flags;
  logic        MFA, RW_RAM, SALU, RF_RW, SSAB, SSOP, SMA, STA;
  logic        MAR_EN, SR_EN, MDR_EN, IR_EN, SHT_EN, ISE_EN;
  logic        SGN_EN;
  logic [1:0]  DSS, WRA, SRA, SRB, SISE, SALUB;
  logic [3:0]  ALUA;
  logic        DP_CLR, FAULT;
  logic [4:0]  STATE;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  control_unit #(.MEM_TIMEOUT(TMO), .TO_W(4)) dut (
    .CLK(CLK), .CLR(CLR), .IR(IR), .MFC(MFC), .Flags(Flags),
    .MFA(MFA), .RW_RAM(RW_RAM), .SALU(SALU), .RF_RW(RF_RW),
    .SSAB(SSAB), .SSOP(SSOP), .SMA(SMA), .STA(STA),
    .MAR_EN(MAR_EN), .SR_EN(SR_EN), .MDR_EN(MDR_EN),
    .IR_EN(IR_EN), .SHT_EN(SHT_EN), .ISE_EN(ISE_EN),
    .SGN_EN(SGN_EN), .DSS(DSS), .WRA(WRA), .SRA(SRA),
    .SRB(SRB), .SISE(SISE), .SALUB(SALUB), .ALUA(ALUA),
    .DP_CLR(DP_CLR), .FAULT(FAULT), .STATE(STATE)
  );

  typedef struct packed {
    logic mfa; logic rw; logic salu; logic rfrw;
    logic ssab; logic ssop; logic sma; logic sta;
    logic mar; logic sr; logic mdr; logic ire;
    logic sht; logic ise; logic sgn;
    logic [1:0] dss; logic [1:0] wra; logic [1:0] sra;
    logic [1:0] srb; logic [1:0] sise; logic [1:0] salub;
    logic [3:0] alua; logic dpclr; logic flt;
  } outs_t;

  outs_t obs;
  assign obs = {MFA, RW_RAM, SALU, RF_RW, SSAB, SSOP, SMA, STA,
                MAR_EN, SR_EN, MDR_EN, IR_EN, SHT_EN, ISE_EN,
                SGN_EN, DSS, WRA, SRA, SRB, SISE, SALUB, ALUA,
                DP_CLR, FAULT};

  typedef struct {
    state_t st;
    logic   mfc;
  } step_t;

  step_t q[$];
  bit    faulted;

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  // odd condition codes are the complement of the even one below
  function automatic bit model_cond(logic [3:0] c, logic [3:0] f);
    bit n, z, cf, v, r;
    n = f[3]; z = f[2]; cf = f[1]; v = f[0];
    case (c[3:1])
      3'd0: r = z;
      3'd1: r = cf;
      3'd2: r = n;
      3'd3: r = v;
      3'd4: r = cf && !z;
      3'd5: r = (n == v);
      3'd6: r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'hf) return 1'b0;
    return c[0] ? !r : r;
  endfunction

  function automatic outs_t model_out(state_t s, logic [31:0] ir);
    outs_t o;
    o = '0;
    case (s)
      S_RESET: o.dpclr = 1'b1;
      S_FETCH0: begin
        o.alua = 4'b1101; o.salub = 2'd3; o.ssop = 1'b1;
        o.srb = 2'd1; o.mar = 1'b1;
      end
      S_FETCH1: begin
        o.sra = 2'd1; o.salub = 2'd1; o.alua = 4'b0100;
        o.wra = 2'd1; o.rfrw = 1'b1; o.mfa = 1'b1; o.rw = 1'b1;
      end
      S_FETCH2: begin
        o.mfa = 1'b1; o.rw = 1'b1; o.ire = 1'b1;
      end
      S_DP: begin
        o.salu = 1'b1; o.srb = 2'd3; o.sht = 1'b1;
        if (ir[25]) o.ise = 1'b1;
        else        o.ssop = 1'b1;
        o.rfrw = !(ir[24] && !ir[23]);
        o.sr = ir[20];
      end
      S_MEMADDR: begin
        o.salub = 2'd3; o.ise = 1'b1; o.sise = 2'd1;
        o.mar = 1'b1;
        o.alua = ir[23] ? 4'b0100 : 4'b0010;
      end
      S_ST0: begin
        o.srb = 2'd2; o.alua = 4'b1101; o.salub = 2'd3;
        o.ssop = 1'b1; o.mdr = 1'b1;
      end
      S_ST1: begin
        o.mfa = 1'b1; o.dss = 2'd1;
      end
      S_LD0: begin
        o.mfa = 1'b1; o.rw = 1'b1; o.dss = 2'd1; o.sma = 1'b1;
        o.sgn = 1'b1; o.mdr = 1'b1;
      end
      S_LD1: begin
        o.alua = 4'b1101; o.rfrw = 1'b1;
      end
      S_LINK: begin
        o.srb = 2'd1; o.salub = 2'd3; o.ssop = 1'b1;
        o.alua = 4'b1101; o.wra = 2'd2; o.rfrw = 1'b1;
      end
      S_BR: begin
        o.sra = 2'd1; o.salub = 2'd2; o.alua = 4'b0100;
        o.wra = 2'd1; o.rfrw = 1'b1;
      end
      S_FAULT: o.flt = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic void push(state_t s, logic m);
    step_t e;
    e.st = s;
    e.mfc = m;
    q.push_back(e);
  endfunction

  // d idle wait cycles then MFC; too many idle cycles -> FAULT
  function automatic void push_wait(state_t s, int d);
    if (d >= TMO) begin
      for (int i = 0; i < TMO; i++) push(s, 1'b0);
      for (int i = 0; i < 3; i++) push(S_FAULT, rnd());
      faulted = 1'b1;
    end else begin
      for (int i = 0; i < d; i++) push(s, 1'b0);
      push(s, 1'b1);
    end
  endfunction

  function automatic void build(logic [31:0] ir, logic [3:0] f,
                                int dly);
    q.delete();
    faulted = 1'b0;
    push(S_FETCH0, rnd());
    push(S_FETCH1, rnd());
    push_wait(S_FETCH2, dly);
    if (faulted) return;
    push(S_DECODE, rnd());
    if (!model_cond(ir[31:28], f)) return;
    if (ir[27:26] == 2'b00) begin
      push(S_DP, rnd());
    end else if (ir[27:25] == 3'b010) begin
      push(S_MEMADDR, rnd());
      if (ir[20]) begin
        push_wait(S_LD0, dly);
        if (!faulted) push(S_LD1, rnd());
      end else begin
        push(S_ST0, rnd());
        push_wait(S_ST1, dly);
      end
    end else if (ir[27:25] == 3'b101) begin
      if (ir[24]) push(S_LINK, rnd());
      push(S_BR, rnd());
    end
  endfunction

  task automatic check(input string tag, input state_t st,
                       input logic [31:0] ir);
    outs_t e;
    e = model_out(st, ir);
    checks++;
    assert (STATE === 5'(st)) else begin
      errors++;
      $error("FAIL %s state got %0d want %0d", tag, STATE, st);
    end
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s outs got %h want %h (state %0d)",
             tag, obs, e, st);
    end
  endtask

  // entered and left at posedge+1; limit<0 runs the whole trace
  task automatic run(input string tag, input logic [31:0] ir,
                     input logic [3:0] f, input int dly,
                     input int limit);
    IR = ir;
    Flags = f;
    build(ir, f, dly);
    for (int i = 0; i < q.size(); i++) begin
      if (limit >= 0 && i >= limit) break;
      MFC = q[i].mfc;
      @(negedge CLK);
      check(tag, q[i].st, ir);
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic release_reset();
    CLR = 1'b1;
    @(negedge CLK);
    check("rst_hold", S_RESET, IR);
    @(posedge CLK);
    #1;
  endtask

  task automatic async_reset(input string tag);
    #2;
    CLR = 1'b0;
    #1;
    check(tag, S_RESET, IR);
    @(posedge CLK);
    #1;
    release_reset();
  endtask

  initial begin
    CLR = 1'b0;
    IR = 32'h0;
    MFC = 1'b0;
    Flags = 4'h0;
    #1;
    check("reset", S_RESET, IR);
    repeat (2) @(posedge CLK);
    #1;
    release_reset();

    run("add",      32'hE0821003, 4'b0000, 1,  -1);
    run("eq_fail",  32'h00821003, 4'b0000, 0,  -1);
    run("eq_pass",  32'h00821003, 4'b0100, 0,  -1);
    run("cmp",      32'hE1510002, 4'b0000, 0,  -1);
    run("dp_imm",   32'hE2921001, 4'b0000, 0,  -1);
    run("ldr",      32'hE5912004, 4'b0000, 2,  -1);
    run("str_sub",  32'hE5012004, 4'b0000, 1,  -1);
    run("bl",       32'hEB000010, 4'b0000, 0,  -1);
    run("b",        32'hEA000010, 4'b0000, 0,  -1);
    run("never",    32'hF0821003, 4'b1111, 0,  -1);
    run("late_mfc", 32'hE5912004, 4'b0000, TMO - 1, -1);

    for (int k = 0; k < 40; k++) begin
      logic [31:0] r;
      int cls;
      r = $urandom;
      cls = int'($urandom_range(0, 4));
      case (cls)
        0: r[27:26] = 2'b00;
        1: r[27:25] = 3'b010;
        2: r[27:25] = 3'b101;
        3: r[27:25] = 3'b011;
        default: r[27:26] = 2'b11;
      endcase
      if ($urandom_range(0, 3) != 0) r[31:28] = 4'he;
      run("rand", r, 4'($urandom), int'($urandom_range(0, 3)), -1);
    end

    // stop in the third LD0 wait cycle and pull reset
    run("ldr_cut", 32'hE5912004, 4'b0000, 3, 10);
    checks++;
    assert (MFA === 1'b1) else begin
      errors++;
      $error("FAIL mid_ld0_mfa got %b want 1", MFA);
    end
    async_reset("rst_mid_ld0");

    run("timeout", 32'hE0821003, 4'b0000, TMO, -1);
    async_reset("rst_fault");

    run("recover", 32'hE0821003, 4'b0000, 0, -1);
    MFC = 1'b0;
    @(negedge CLK);
    check("final", S_FETCH0, IR);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
